// File: rtl/urv_mem_arbiter.sv
// Beat formats and widths for the shared L1-to-bridge memory port.
package urv_mem_pkg;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MASK_W  = 4;
    localparam int BURST_W = 4;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    typedef struct packed {
        logic               req_type;
        logic [ADDR_W-1:0]  req_addr;
        logic [DATA_W-1:0]  req_data;
        logic [MASK_W-1:0]  req_mask;
        logic [BURST_W-1:0] req_burst;
    } mem_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] resp_data;
        logic              resp_last;
    } mem_resp_t;
endpackage

// Round-robin 2:1 arbiter (M0 icache, M1 dcache) holding the grant for a whole burst.
// Grant takes 1 cycle; beats then pass combinationally with ready/valid straight through.
module urv_mem_arbiter
    import urv_mem_pkg::*;
(
    input  logic      clk,
    input  logic      rstn,
    input  logic      m0_req_valid,
    output logic      m0_req_ready,
    input  mem_req_t  m0_req,
    output logic      m0_resp_valid,
    input  logic      m0_resp_ready,
    output mem_resp_t m0_resp,
    input  logic      m1_req_valid,
    output logic      m1_req_ready,
    input  mem_req_t  m1_req,
    output logic      m1_resp_valid,
    input  logic      m1_resp_ready,
    output mem_resp_t m1_resp,
    output logic      s_req_valid,
    input  logic      s_req_ready,
    output mem_req_t  s_req,
    input  logic      s_resp_valid,
    output logic      s_resp_ready,
    input  mem_resp_t s_resp,
    output logic      busy,
    output logic      grant_id
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               rr_pri_q, rr_pri_d;
    logic               type_q, type_d;
    logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [BURST_W-1:0] burst_q, burst_d;

    logic               g_req_valid;
    logic               g_resp_ready;
    mem_req_t           g_req;
    logic               first_beat;
    logic               cur_type;
    logic [BURST_W-1:0] cur_burst;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            rr_pri_q   <= 1'b0;
            type_q     <= 1'b0;
            beat_cnt_q <= '0;
            burst_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_pri_q   <= rr_pri_d;
            type_q     <= type_d;
            beat_cnt_q <= beat_cnt_d;
            burst_q    <= burst_d;
        end
    end

    always_comb begin
        g_req_valid  = grant_q ? m1_req_valid  : m0_req_valid;
        g_req        = grant_q ? m1_req        : m0_req;
        g_resp_ready = grant_q ? m1_resp_ready : m0_resp_ready;
        // beat_cnt is only nonzero mid-write, so zero marks the first beat of a burst
        first_beat   = (beat_cnt_q == '0);
        cur_burst    = first_beat ? g_req.req_burst : burst_q;
        cur_type     = first_beat ? g_req.req_type  : type_q;

        state_d       = state_q;
        grant_d       = grant_q;
        rr_pri_d      = rr_pri_q;
        type_d        = type_q;
        beat_cnt_d    = beat_cnt_q;
        burst_d       = burst_q;
        s_req         = g_req;
        s_req_valid   = 1'b0;
        m0_req_ready  = 1'b0;
        m1_req_ready  = 1'b0;
        m0_resp       = s_resp;
        m1_resp       = s_resp;
        m0_resp_valid = 1'b0;
        m1_resp_valid = 1'b0;
        s_resp_ready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_req_valid || m1_req_valid) begin
                    if (m0_req_valid && m1_req_valid) begin
                        grant_d  = rr_pri_q;
                        rr_pri_d = ~rr_pri_q;
                    end else begin
                        grant_d = m1_req_valid;
                    end
                    state_d = REQ;
                end
            end
            REQ: begin
                s_req_valid  = g_req_valid;
                m0_req_ready = !grant_q && s_req_ready;
                m1_req_ready =  grant_q && s_req_ready;
                if (g_req_valid && s_req_ready) begin
                    if (first_beat) begin
                        burst_d = g_req.req_burst;
                        type_d  = g_req.req_type;
                    end
                    if (cur_type == REQ_READ || beat_cnt_q == cur_burst) begin
                        state_d    = RESP;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            RESP: begin
                m0_resp_valid = !grant_q && s_resp_valid;
                m1_resp_valid =  grant_q && s_resp_valid;
                s_resp_ready  = g_resp_ready;
                if (s_resp_valid && g_resp_ready && s_resp.resp_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;
endmodule

// File: tb/tb_urv_mem_arbiter.sv
// Bench for urv_mem_arbiter: cycle vector table, directed burst sequences, random traffic vs. a model.
module tb_urv_mem_arbiter;
    import urv_mem_pkg::*;

    logic      clk = 1'b0;
    logic      rstn;
    logic      m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready;
    logic      m1_req_valid, m1_req_ready, m1_resp_valid, m1_resp_ready;
    mem_req_t  m0_req, m1_req, s_req;
    mem_resp_t m0_resp, m1_resp, s_resp;
    logic      s_req_valid, s_req_ready, s_resp_valid, s_resp_ready;
    logic      busy, grant_id;

    int n_cmp = 0;
    int n_bad = 0;

    urv_mem_arbiter dut (
        .clk(clk), .rstn(rstn),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req(m0_req),
        .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_resp(m0_resp),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req(m1_req),
        .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_resp(m1_resp),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req(s_req),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_resp(s_resp),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {m0_req_ready, m1_req_ready, s_req_valid, m0_resp_valid, m1_resp_valid, s_resp_ready, busy, grant_id}
    function automatic logic [7:0] outs();
        return {m0_req_ready, m1_req_ready, s_req_valid, m0_resp_valid, m1_resp_valid,
                s_resp_ready, busy, grant_id};
    endfunction

    function automatic mem_req_t mk_req(input logic t, input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] m, input logic [3:0] b);
        mem_req_t r;
        r.req_type  = t;
        r.req_addr  = a;
        r.req_data  = d;
        r.req_mask  = m;
        r.req_burst = b;
        return r;
    endfunction

    task automatic idle_inputs();
        m0_req_valid = 0; m1_req_valid = 0; m0_req = '0; m1_req = '0;
        m0_resp_ready = 0; m1_resp_ready = 0;
        s_req_ready = 0; s_resp_valid = 0; s_resp = '0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        idle_inputs();
        rstn = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_outs", 128'(outs()), 128'(8'h00));
        rstn = 1;
    endtask

    typedef struct {
        logic [7:0] in;   // {rstn, m0v, m1v, s_req_ready, s_resp_valid, resp_last, m0_resp_ready, m1_resp_ready}
        logic [7:0] exp;  // same order as outs()
    } vec_t;
    vec_t vt[$];

    // Random-traffic environment and reference model state
    logic        t_act[2], t_type[2];
    int          t_burst[2], t_sent[2], t_nreq[2], t_gap[2], t_done[2];
    logic [31:0] t_addr[2];
    logic [31:0] t_data[2][16];
    logic [3:0]  t_mask[2][16];
    logic        mv[2], mrr[2];
    int          mdl_phase, mdl_owner, mdl_rr, mdl_gid, sl_left;
    logic        sl_vld, sl_last;
    logic [31:0] sl_dat;
    logic [7:0]  exp_o;

    task automatic new_txn(input int m);
        t_act[m]   = 1;
        t_type[m]  = 1'($urandom_range(0, 1));
        t_burst[m] = ($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(0, 4));
        t_nreq[m]  = t_type[m] ? t_burst[m] + 1 : 1;
        t_addr[m]  = $urandom;
        t_sent[m]  = 0;
        for (int k = 0; k < 16; k++) begin
            t_data[m][k] = $urandom;
            t_mask[m][k] = 4'($urandom);
        end
    endtask

    function automatic mem_req_t beat_req(input int m);
        int idx;
        idx = (t_sent[m] < 16) ? t_sent[m] : 15;
        return mk_req(t_type[m], t_addr[m], t_data[m][idx], t_mask[m][idx], 4'(t_burst[m]));
    endfunction

    initial begin
        int got, wbeat, n;
        logic seen_m0, prev;
        logic [31:0] d;

        rstn = 0;
        idle_inputs();
        reset_dut();

        // ---- cycle vector table ----
        vt.push_back('{8'b1_1_0_0_0_0_0_0, 8'b0_0_0_0_0_0_0_0}); // M0 read b3 requests, IDLE
        vt.push_back('{8'b1_1_0_1_0_0_0_0, 8'b1_0_1_0_0_0_1_0}); // REQ, one beat
        vt.push_back('{8'b1_0_0_0_1_0_1_0, 8'b0_0_0_1_0_1_1_0}); // resp beat 1
        vt.push_back('{8'b1_0_0_0_1_0_0_0, 8'b0_0_0_1_0_0_1_0}); // M0 stalls
        vt.push_back('{8'b1_0_0_0_1_0_1_0, 8'b0_0_0_1_0_1_1_0}); // beat 2
        vt.push_back('{8'b1_0_0_0_1_0_1_0, 8'b0_0_0_1_0_1_1_0}); // beat 3
        vt.push_back('{8'b1_0_0_0_1_1_1_0, 8'b0_0_0_1_0_1_1_0}); // beat 4, last
        vt.push_back('{8'b1_1_1_0_0_0_0_0, 8'b0_0_0_0_0_0_0_0}); // both request: M0 wins
        vt.push_back('{8'b1_1_1_1_0_0_0_0, 8'b1_0_1_0_0_0_1_0});
        vt.push_back('{8'b1_0_1_0_1_0_1_1, 8'b0_0_0_1_0_1_1_0});
        vt.push_back('{8'b1_0_1_0_1_0_1_1, 8'b0_0_0_1_0_1_1_0});
        vt.push_back('{8'b1_0_1_0_1_0_1_1, 8'b0_0_0_1_0_1_1_0});
        vt.push_back('{8'b1_0_1_0_1_1_1_1, 8'b0_0_0_1_0_1_1_0});
        vt.push_back('{8'b1_0_1_0_0_0_0_0, 8'b0_0_0_0_0_0_0_0}); // M1 granted next
        vt.push_back('{8'b1_0_1_1_0_0_0_0, 8'b0_1_1_0_0_0_1_1}); // single write beat
        vt.push_back('{8'b1_0_0_0_1_1_1_1, 8'b0_0_0_0_1_1_1_1});
        vt.push_back('{8'b1_0_0_0_0_0_0_0, 8'b0_0_0_0_0_0_0_1}); // grant_id holds
        vt.push_back('{8'b1_0_1_0_0_0_0_0, 8'b0_0_0_0_0_0_0_1});
        vt.push_back('{8'b1_0_1_1_0_0_0_0, 8'b0_1_1_0_0_0_1_1});
        vt.push_back('{8'b0_0_0_0_1_0_1_1, 8'b0_0_0_0_1_1_1_1}); // reset mid-RESP
        vt.push_back('{8'b1_0_1_0_0_0_0_0, 8'b0_0_0_0_0_0_0_0}); // back in IDLE
        vt.push_back('{8'b1_0_1_1_0_0_0_0, 8'b0_1_1_0_0_0_1_1});
        vt.push_back('{8'b1_0_0_0_1_1_1_1, 8'b0_0_0_0_1_1_1_1});
        vt.push_back('{8'b1_0_0_0_0_0_0_0, 8'b0_0_0_0_0_0_0_1});

        m0_req = mk_req(REQ_READ, 32'h1000, 32'hA0, 4'hF, 4'd3);
        m1_req = mk_req(REQ_WRITE, 32'h2000, 32'hB1, 4'h3, 4'd0);
        foreach (vt[i]) begin
            @(negedge clk);
            {rstn, m0_req_valid, m1_req_valid, s_req_ready, s_resp_valid, s_resp.resp_last,
             m0_resp_ready, m1_resp_ready} = vt[i].in;
            s_resp.resp_data = 32'hD000 + 32'(i);
            #1;
            check($sformatf("vec%0d", i), 128'(outs()), 128'(vt[i].exp));
            if (vt[i].exp[5])
                check($sformatf("vec%0d_sreq", i), 128'(s_req), 128'(vt[i].exp[0] ? m1_req : m0_req));
            if (vt[i].exp[4]) check($sformatf("vec%0d_m0resp", i), 128'(m0_resp), 128'(s_resp));
            if (vt[i].exp[3]) check($sformatf("vec%0d_m1resp", i), 128'(m1_resp), 128'(s_resp));
        end

        // ---- M1 write burst 7 with s_req_ready toggling ----
        reset_dut();
        got = 0; wbeat = 0; seen_m0 = 0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            @(negedge clk);
            m1_req_valid = 1;
            m1_req = mk_req(REQ_WRITE, 32'h3000, 32'(wbeat), 4'hF, 4'd7);
            s_req_ready = c[0];
            #1;
            if (m0_resp_valid || m0_req_ready) seen_m0 = 1;
            if (s_req_valid && s_req_ready) begin
                check("wr_order", 128'(s_req.req_data), 128'(got));
                got++;
            end
            if (m1_req_valid && m1_req_ready) wbeat++;
        end
        check("wr_count", 128'(got), 128'(8));
        @(negedge clk);
        m1_req_valid = 0; s_req_ready = 0; m0_resp_ready = 1; m1_resp_ready = 1;
        s_resp_valid = 1; s_resp.resp_data = 32'hC0DE; s_resp.resp_last = 1;
        #1;
        if (m0_resp_valid) seen_m0 = 1;
        check("wr_resp", 128'({m1_resp_valid, m0_resp_valid, s_resp_ready, m1_resp.resp_data}),
              128'({1'b1, 1'b0, 1'b1, 32'hC0DE}));
        @(negedge clk);
        s_resp_valid = 0;
        #1;
        check("wr_m0_quiet", 128'(seen_m0), 128'(0));
        check("wr_done", 128'({busy, grant_id}), 128'(2'b01));

        // ---- M0 read burst 3, resp_ready stalled 5 cycles on beat 2 ----
        reset_dut();
        @(negedge clk);
        m0_req_valid = 1; m0_req = mk_req(REQ_READ, 32'h1000, 32'h0, 4'h0, 4'd3);
        #1;
        check("rd_idle", 128'(outs()), 128'(8'h00));
        @(negedge clk);
        s_req_ready = 1;
        #1;
        check("rd_grant", 128'({busy, grant_id, s_req_valid, m0_req_ready, s_req.req_addr}),
              128'({4'b1011, 32'h1000}));
        @(negedge clk);
        m0_req_valid = 0; s_req_ready = 0; m0_resp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            d = 32'h5000 + 32'(k);
            s_resp_valid = 1; s_resp.resp_data = d; s_resp.resp_last = (k == 3);
            if (k == 1) begin
                m0_resp_ready = 0;
                for (int s = 0; s < 5; s++) begin
                    #1;
                    check("rd_stall", 128'({s_resp_ready, m0_resp_valid, m1_resp_valid}), 128'(3'b010));
                    @(negedge clk);
                end
                m0_resp_ready = 1;
            end
            #1;
            check($sformatf("rd_beat%0d", k),
                  128'({m0_resp_valid, m1_resp_valid, s_resp_ready, m0_resp.resp_data, m0_resp.resp_last}),
                  128'({1'b1, 1'b0, 1'b1, d, (k == 3)}));
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check("rd_done", 128'(busy), 128'(0));

        // ---- both masters requesting continuously: grants alternate ----
        reset_dut();
        @(negedge clk);
        m0_req_valid = 1; m1_req_valid = 1;
        m0_req = mk_req(REQ_READ, 32'h40, 32'h0, 4'h0, 4'd0);
        m1_req = mk_req(REQ_READ, 32'h80, 32'h0, 4'h0, 4'd0);
        s_req_ready = 1; s_resp_valid = 1; s_resp.resp_data = 32'h77; s_resp.resp_last = 1;
        m0_resp_ready = 1; m1_resp_ready = 1;
        n = 0; prev = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (busy && !prev) begin
                check($sformatf("alt%0d", n), 128'(grant_id), 128'(n % 2));
                n++;
            end
            prev = busy;
        end
        check("alt_count", 128'(n), 128'(4));

        // ---- random traffic against a transaction-level model ----
        reset_dut();
        mdl_phase = 0; mdl_owner = 0; mdl_rr = 0; mdl_gid = 0;
        sl_left = 0; sl_vld = 0; sl_last = 0; sl_dat = '0;
        for (int m = 0; m < 2; m++) begin
            t_act[m] = 0; t_gap[m] = 0; t_done[m] = 0; t_sent[m] = 0; t_nreq[m] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (!t_act[m]) begin
                    if (t_gap[m] > 0) t_gap[m]--;
                    else new_txn(m);
                end
                mv[m]  = t_act[m] && (t_sent[m] < t_nreq[m]);
                mrr[m] = ($urandom_range(0, 3) != 0);
            end
            if (sl_left > 0 && !sl_vld && $urandom_range(0, 2) != 0) begin
                sl_vld = 1; sl_dat = $urandom; sl_last = (sl_left == 1);
            end
            m0_req_valid = mv[0]; m0_req = beat_req(0); m0_resp_ready = mrr[0];
            m1_req_valid = mv[1]; m1_req = beat_req(1); m1_resp_ready = mrr[1];
            s_req_ready  = ($urandom_range(0, 2) != 0);
            s_resp_valid = sl_vld; s_resp.resp_data = sl_dat; s_resp.resp_last = sl_last;
            #1;
            exp_o = '0;
            if (mdl_phase == 0) begin
                exp_o[0] = mdl_gid[0];
            end else begin
                exp_o[1] = 1'b1;
                exp_o[0] = mdl_owner[0];
                if (mdl_phase == 1) begin
                    exp_o[5] = mv[mdl_owner];
                    if (mdl_owner == 1) exp_o[6] = s_req_ready; else exp_o[7] = s_req_ready;
                end else begin
                    if (mdl_owner == 1) exp_o[3] = sl_vld; else exp_o[4] = sl_vld;
                    exp_o[2] = mrr[mdl_owner];
                end
            end
            check("rand_outs", 128'(outs()), 128'(exp_o));
            if (mdl_phase == 1 && mv[mdl_owner] && s_req_ready) begin
                check("rand_sreq", 128'(s_req), 128'(beat_req(mdl_owner)));
                t_sent[mdl_owner]++;
                if (t_sent[mdl_owner] == t_nreq[mdl_owner]) begin
                    mdl_phase = 2;
                    sl_left = t_type[mdl_owner] ? 1 : t_burst[mdl_owner] + 1;
                end
            end else if (mdl_phase == 2 && sl_vld && mrr[mdl_owner]) begin
                check("rand_resp", 128'(mdl_owner == 1 ? m1_resp : m0_resp), 128'({sl_dat, sl_last}));
                sl_vld = 0;
                sl_left--;
                if (sl_last) begin
                    mdl_phase = 0;
                    t_act[mdl_owner] = 0;
                    t_gap[mdl_owner] = $urandom_range(0, 3);
                    t_done[mdl_owner]++;
                end
            end else if (mdl_phase == 0 && (mv[0] || mv[1])) begin
                if (mv[0] && mv[1]) begin
                    mdl_owner = mdl_rr;
                    mdl_rr = 1 - mdl_rr;
                end else begin
                    mdl_owner = mv[1] ? 1 : 0;
                end
                mdl_gid = mdl_owner;
                mdl_phase = 1;
            end
        end
        check("rand_progress", 128'(t_done[0] > 3 && t_done[1] > 3), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/urv_mem_arbiter.md
Name: urv_mem_arbiter

Overview:
- Two-master, one-slave arbiter for the shared memory port. M0 is the icache refill port; M1 is the dcache refill/writeback port.
- Carries mem_req_t / mem_resp_t beats over valid/ready handshakes.
- Grants round-robin and holds the grant for one full burst transaction (request beats plus response beats).
- Sits between the L1 caches and the bus/memory bridge.

Parameters:
- ADDR_W, MEM_ADDR_W: request address width (from urv_cfg).
- DATA_W, MEM_DATA_W: data beat width.
- MASK_W, MEM_MASK_W: byte mask width.
- BURST_W, MEM_BURST_W: burst field width; req_burst = beats-1.

Ports:
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  synchronous active-low reset
- m0_req_valid  in  1  M0 request beat valid
- m0_req_ready  out  1  M0 request beat accepted
- m0_req  in  $bits(mem_req_t)  M0 request beat
- m0_resp_valid  out  1  response beat to M0
- m0_resp_ready  in  1  M0 can take response
- m0_resp  out  $bits(mem_resp_t)  response beat to M0
- m1_req_valid / m1_req_ready / m1_req / m1_resp_valid / m1_resp_ready / m1_resp: same as M0, for M1
- s_req_valid  out  1  request beat to slave
- s_req_ready  in  1  slave accepts request beat
- s_req  out  $bits(mem_req_t)  forwarded request
- s_resp_valid  in  1  slave response valid
- s_resp_ready  out  1  arbiter accepts response
- s_resp  in  $bits(mem_resp_t)  slave response
- busy  out  1  state != IDLE
- grant_id  out  1  current/last granted master

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous, active-low on rstn.
  - On reset: state=IDLE, grant_id=0, rr_pri=0 (M0 preferred), beat_cnt=0, burst_q=0, busy=0.
  - All ready/valid outputs are 0 in IDLE.
  - Reset asserted mid-burst aborts the transaction unconditionally. Masters and slave are reset by the same rstn.
- Handshake rule: a beat transfers on a cycle where valid && ready. Valid, once raised, holds with stable payload until the transfer; masters and slave guarantee this.
- Write burst format:
  - req_burst+1 request beats, identical req_type/addr/burst, per-beat data/mask.
  - Exactly one response beat with resp_last=1.
- Read burst format:
  - One request beat.
  - req_burst+1 response beats, resp_last=1 on the final beat.
- State IDLE:
  - If only one master's req_valid is high, grant it.
  - If both are high, grant the master selected by rr_pri. rr_pri <= ~granted id.
  - Grant is registered: grant_id <= winner; go to REQ next cycle. Arbitration latency is 1 cycle; no ready is asserted in IDLE.
- State REQ:
  - s_req_valid = granted req_valid; s_req = granted req; granted req_ready = s_req_ready. The non-granted master sees req_ready=0.
  - On the first beat handshake, latch burst_q <= req_burst and type_q <= req_type.
  - Read, or write with beat_cnt==burst_q (first beat uses live req_burst): handshake -> RESP, beat_cnt <= 0.
  - Otherwise, on handshake: beat_cnt <= beat_cnt+1.
  - s_resp_ready=0 in REQ.
- State RESP:
  - granted resp_valid = s_resp_valid; resp payload = s_resp; s_resp_ready = granted resp_ready. The other master sees resp_valid=0.
  - s_req_valid=0 and both req_ready=0.
  - On response handshake with resp_last=1 -> IDLE.
  - Response beats without resp_last keep the RESP state.
- Back-to-back requests:
  - A master with valid still high in the IDLE cycle after completion competes normally. Round-robin guarantees alternation when both request continuously.
- Unused payload: the non-granted master's resp payload is driven with s_resp (only valid is gated).
- Edge cases:
  - req_burst=0: a write is one request beat and one response beat; a read is one request beat and one response beat.
  - Maximum burst (all ones) must not overflow beat_cnt, which is BURST_W wide.

Test Plan:
- Single read, M0 only, addr 0x1000, burst=3: grant next cycle (grant_id=0). One s_req beat, then 4 s_resp beats routed to M0 only. resp_last on beat 4; busy falls the following cycle.
- Simultaneous M0 read and M1 write after reset: M0 wins first (rr_pri=0). M1 waits with req_ready=0 until M0's resp_last handshake, then is granted in the next IDLE cycle.
- M1 write, burst=7, data 0..7, with s_req_ready toggling every other cycle: 8 beats forwarded in order with no drop or duplicate, beat_cnt reaches 7. A single response is returned to M1; M0 sees no valid.
- Both masters hold valid for 4 transactions: grants alternate 0,1,0,1.
- Backpressure: M0 resp_ready=0 for 5 cycles mid-read. s_resp_ready=0 during the stall; the beat is delivered intact afterwards.
- rstn low for 1 cycle during RESP beat 2 of 4: next cycle state=IDLE, busy=0, grant_id=0, all readies 0. A new request is granted normally.
